// File: rtl/max7219_frame_sequencer_pkg.sv
// MAX7219 command sequencer shared definitions:
// register opcodes, FSM encoding, init length, helpers.
package max7219_pkg;

  localparam logic [7:0] OP_NOOP      = 8'h00;
  localparam logic [7:0] OP_DIGIT0    = 8'h01;
  localparam logic [7:0] OP_DECODE    = 8'h09;
  localparam logic [7:0] OP_INTENSITY = 8'h0A;
  localparam logic [7:0] OP_SCANLIM   = 8'h0B;
  localparam logic [7:0] OP_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] OP_TEST      = 8'h0F;

  localparam int INIT_LEN = 6;

  typedef enum logic [1:0] {
    S_WAIT,
    S_INIT,
    S_IDLE,
    S_ROW
  } state_t;

  // Lowest-index set bit; 0 when v is empty.
  function automatic logic [2:0] lowest_set(
    input logic [7:0] v
  );
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_op(
    input logic [2:0] row
  );
    return OP_DIGIT0 + {5'b0, row};
  endfunction

endpackage

// File: rtl/max7219_frame_sequencer_if.sv
// Command word handshake towards the SPI serializer.
// cmd_valid/cmd_data from master, cmd_ready from slave.
interface max7219_frame_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/max7219_frame_sequencer_init_rom.sv
// MAX7219 power-up command table, idx -> {opcode, data}.
// Ports: idx (0..5), word (16-bit command).
module max7219_init_rom
  import max7219_pkg::*;
#(
  parameter logic [3:0] INTENSITY  = 4'h7,
  parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
  input  logic [2:0]  idx,
  output logic [15:0] word
);

  always_comb begin
    word = {OP_NOOP, 8'h00};
    unique case (idx)
      3'd0: word = {OP_SHUTDOWN, 8'h00};
      3'd1: word = {OP_TEST, 8'h00};
      3'd2: word = {OP_DECODE, 8'h00};
      3'd3: word = {OP_SCANLIM, 5'b0, SCAN_LIMIT};
      3'd4: word = {OP_INTENSITY, 4'h0, INTENSITY};
      3'd5: word = {OP_SHUTDOWN, 8'h01};
      default: word = {OP_NOOP, 8'h00};
    endcase
  end

endmodule

// File: rtl/max7219_frame_sequencer.sv
// 8x8 frame buffer + MAX7219 init/row command source.
// Ports: clk, rst_n, fb_we/fb_addr/fb_data, cmd (master), init_done, busy.
module max7219_frame_sequencer
  import max7219_pkg::*;
#(
  parameter int unsigned STARTUP_WAIT   = 10_000_000,
  parameter logic [3:0]  INTENSITY      = 4'h7,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
  parameter int unsigned REFRESH_PERIOD = 27_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fb_we,
  input  logic [2:0] fb_addr,
  input  logic [7:0] fb_data,
  max7219_frame_sequencer_if.master cmd,
  output logic       init_done,
  output logic       busy
);

  localparam logic [31:0] WAIT_LAST =
    (STARTUP_WAIT == 0) ? 32'd0 : 32'(STARTUP_WAIT - 1);
  localparam logic [31:0] REF_LAST =
    (REFRESH_PERIOD == 0) ? 32'd0 : 32'(REFRESH_PERIOD - 1);
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  state_t      state_q, state_n;
  logic [31:0] wait_cnt_q;
  logic [31:0] ref_cnt_q;
  logic [2:0]  idx_q;
  logic [2:0]  row_q;
  logic [7:0]  row_data_q;
  logic [7:0]  fb_q [8];
  logic [7:0]  dirty_q, dirty_n;
  logic        stale_q;
  logic        init_done_q;
  logic [15:0] rom_word;

  logic       xfer;
  logic       ref_hit;
  logic       row_wr;
  logic       start_row;
  logic [7:0] wr_vec;
  logic [7:0] pend_vec;
  logic [2:0] pick;

  max7219_init_rom #(
    .INTENSITY (INTENSITY),
    .SCAN_LIMIT(SCAN_LIMIT)
  ) u_rom (
    .idx (idx_q),
    .word(rom_word)
  );

  assign xfer = cmd.cmd_valid && cmd.cmd_ready;
  assign ref_hit = init_done_q
                && (REFRESH_PERIOD != 0)
                && (ref_cnt_q == REF_LAST);
  assign wr_vec = fb_we ? (8'b1 << fb_addr) : 8'b0;
  assign row_wr = fb_we && (fb_addr == row_q);
  assign start_row = (state_q == S_IDLE) && (|dirty_q);

  // Row choice also sees same-cycle writes so a
  // lower row written now still goes first.
  assign pend_vec = dirty_q | wr_vec | {8{ref_hit}};
  assign pick = lowest_set(pend_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_n = S_INIT;
      end
      S_INIT: begin
        if (xfer && idx_q == INIT_LAST) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (|dirty_q) state_n = S_ROW;
      end
      S_ROW: begin
        if (xfer) state_n = S_IDLE;
      end
      default: state_n = S_WAIT;
    endcase
  end

  always_comb begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_data  = 16'h0000;
    unique case (state_q)
      S_INIT: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_data  = rom_word;
      end
      S_ROW: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_data  = {digit_op(row_q), row_data_q};
      end
      default: begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_data  = 16'h0000;
      end
    endcase
    init_done = init_done_q;
    busy = (state_q != S_IDLE) || (|dirty_q);
  end

  // A row rewritten while on offer keeps its dirty bit
  // through the transfer; refresh and writes always set.
  always_comb begin
    dirty_n = dirty_q;
    if (state_q == S_ROW && xfer && !stale_q && !row_wr) begin
      dirty_n[row_q] = 1'b0;
    end
    dirty_n = dirty_n | wr_vec | {8{ref_hit}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      dirty_q     <= 8'hFF;
      stale_q     <= 1'b0;
      row_q       <= '0;
      row_data_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        fb_q[i] <= '0;
      end
    end else begin
      dirty_q <= dirty_n;

      if (state_q == S_WAIT && wait_cnt_q != WAIT_LAST) begin
        wait_cnt_q <= wait_cnt_q + 32'd1;
      end

      if (state_q == S_INIT && xfer) begin
        idx_q <= idx_q + 3'd1;
        if (idx_q == INIT_LAST) init_done_q <= 1'b1;
      end

      if (init_done_q && REFRESH_PERIOD != 0) begin
        ref_cnt_q <= ref_hit ? 32'd0 : ref_cnt_q + 32'd1;
      end

      if (fb_we) fb_q[fb_addr] <= fb_data;

      // Same-cycle write to the chosen row bypasses fb.
      if (start_row) begin
        row_q <= pick;
        row_data_q <= (fb_we && fb_addr == pick)
                    ? fb_data : fb_q[pick];
      end

      stale_q <= (state_q == S_ROW) && !xfer
              && (stale_q || row_wr);
    end
  end

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Directed bench for max7219_frame_sequencer: boot, backpressure,
// row ordering, rewrite-on-offer, async reset, periodic refresh.
module tb_max7219_frame_sequencer;

  typedef struct {
    string       name;
    logic [15:0] word;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fb_we;
  logic [2:0] fb_addr;
  logic [7:0] fb_data;
  logic       ready_a;
  logic       init_done_a, busy_a;
  logic       fb_we_b;
  logic [2:0] fb_addr_b;
  logic [7:0] fb_data_b;
  logic       init_done_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] qa [$];
  logic [15:0] qb [$];
  int          tb_cyc [$];

  vec_t boot_tbl [14];
  vec_t t3_tbl [2];
  vec_t t4_tbl [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_frame_sequencer_if ia ();
  max7219_frame_sequencer_if ib ();

  assign ia.cmd_ready = ready_a;
  assign ib.cmd_ready = 1'b1;

  max7219_frame_sequencer #(
    .STARTUP_WAIT  (4),
    .INTENSITY     (4'h7),
    .SCAN_LIMIT    (3'd7),
    .REFRESH_PERIOD(0)
  ) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .cmd      (ia),
    .init_done(init_done_a),
    .busy     (busy_a)
  );

  max7219_frame_sequencer #(
    .STARTUP_WAIT  (4),
    .INTENSITY     (4'h7),
    .SCAN_LIMIT    (3'd7),
    .REFRESH_PERIOD(50)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .fb_we    (fb_we_b),
    .fb_addr  (fb_addr_b),
    .fb_data  (fb_data_b),
    .cmd      (ib),
    .init_done(init_done_b),
    .busy     (busy_b)
  );

  // Inputs move only at posedge+1, so a handshake seen
  // here completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n && ia.cmd_valid && ia.cmd_ready) begin
      qa.push_back(ia.cmd_data);
    end
    if (rst_n && ib.cmd_valid && ib.cmd_ready) begin
      qb.push_back(ib.cmd_data);
      tb_cyc.push_back(cyc);
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    tb_cyc.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_a(int n, int budget, string name);
    int k;
    k = 0;
    while (qa.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({name, " word count"}, 32'(qa.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] qa_at(int i);
    return (i < qa.size()) ? 32'(qa[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qb_at(int i);
    return (i < qb.size()) ? 32'(qb[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic check_boot(string tag);
    for (int i = 0; i < 14; i++) begin
      check({tag, " ", boot_tbl[i].name},
            qa_at(i), 32'(boot_tbl[i].word));
    end
  endtask

  task automatic write_row(logic [2:0] a, logic [7:0] d);
    fb_we = 1'b1;
    fb_addr = a;
    fb_data = d;
    tick();
    fb_we = 1'b0;
  endtask

  initial begin
    int k;
    boot_tbl[0] = '{"shutdown0", 16'h0C00};
    boot_tbl[1] = '{"test_off", 16'h0F00};
    boot_tbl[2] = '{"decode", 16'h0900};
    boot_tbl[3] = '{"scanlim", 16'h0B07};
    boot_tbl[4] = '{"intensity", 16'h0A07};
    boot_tbl[5] = '{"shutdown1", 16'h0C01};
    for (int i = 0; i < 8; i++) begin
      boot_tbl[6 + i] = '{$sformatf("digit%0d", i),
                          {8'(i + 1), 8'h00}};
    end
    t3_tbl[0] = '{"row0 first", 16'h013C};
    t3_tbl[1] = '{"row3 second", 16'h04A5};
    t4_tbl[0] = '{"old row5", 16'h0611};
    t4_tbl[1] = '{"new row5", 16'h06FF};

    fb_we = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    fb_we_b = 1'b0;
    fb_addr_b = '0;
    fb_data_b = '0;
    ready_a = 1'b1;

    // 1: reset values, startup wait, boot stream
    rst_n = 1'b0;
    #1;
    check("rst valid", 32'(ia.cmd_valid), 32'd0);
    check("rst data", 32'(ia.cmd_data), 32'h0);
    check("rst init_done", 32'(init_done_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("startup quiet %0d", i),
            32'(ia.cmd_valid), 32'd0);
    end
    @(negedge clk);
    check("first offer valid", 32'(ia.cmd_valid), 32'd1);
    check("first offer data", 32'(ia.cmd_data), 32'h0C00);
    check("init_done before", 32'(init_done_a), 32'd0);
    wait_a(14, 100, "boot");
    check_boot("boot");
    check("boot init_done", 32'(init_done_a), 32'd1);
    repeat (4) tick();
    check("boot busy", 32'(busy_a), 32'd0);
    check("boot no extra", 32'(qa.size()), 32'd14);

    // 2: backpressure on 0B07
    do_reset();
    k = 0;
    while (qa.size() < 3 && k < 50) begin
      tick();
      k++;
    end
    check("bp reach word3", 32'(qa.size()), 32'd3);
    ready_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp hold valid %0d", i),
            32'(ia.cmd_valid), 32'd1);
      check($sformatf("bp hold data %0d", i),
            32'(ia.cmd_data), 32'h0B07);
    end
    tick();
    ready_a = 1'b1;
    wait_a(14, 100, "bp");
    check_boot("bp");
    repeat (4) tick();
    check("bp no extra", 32'(qa.size()), 32'd14);
    check("bp busy", 32'(busy_a), 32'd0);

    // 3: back-to-back writes, lowest row first
    qa.delete();
    write_row(3'd3, 8'hA5);
    write_row(3'd0, 8'h3C);
    repeat (20) tick();
    check("t3 count", 32'(qa.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      check({"t3 ", t3_tbl[i].name}, qa_at(i),
            32'(t3_tbl[i].word));
    end
    check("t3 busy", 32'(busy_a), 32'd0);

    // 4: rewrite of a row while it is on offer
    qa.delete();
    ready_a = 1'b0;
    write_row(3'd5, 8'h11);
    k = 0;
    while (!(ia.cmd_valid && ia.cmd_data == 16'h0611)
           && k < 10) begin
      tick();
      k++;
    end
    check("t4 offer seen", 32'(ia.cmd_data), 32'h0611);
    write_row(3'd5, 8'hFF);
    @(negedge clk);
    check("t4 data held", 32'(ia.cmd_data), 32'h0611);
    check("t4 valid held", 32'(ia.cmd_valid), 32'd1);
    tick();
    ready_a = 1'b1;
    repeat (20) tick();
    check("t4 count", 32'(qa.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      check({"t4 ", t4_tbl[i].name}, qa_at(i),
            32'(t4_tbl[i].word));
    end

    // 6: async reset after 3 init words
    do_reset();
    k = 0;
    while (qa.size() < 3 && k < 50) begin
      tick();
      k++;
    end
    check("t6 reach word3", 32'(qa.size()), 32'd3);
    check("t6 offering", 32'(ia.cmd_valid), 32'd1);
    rst_n = 1'b0;
    qa.delete();
    #1;
    check("t6 async valid", 32'(ia.cmd_valid), 32'd0);
    check("t6 async data", 32'(ia.cmd_data), 32'h0);
    check("t6 async init_done", 32'(init_done_a), 32'd0);
    check("t6 async busy", 32'(busy_a), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    wait_a(14, 100, "restart");
    check_boot("restart");

    // 5: periodic full-frame refresh (period 50)
    do_reset();
    k = 0;
    while (qb.size() < 38 && k < 400) begin
      tick();
      k++;
    end
    check("t5 word count", 32'(qb.size() >= 38), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check({"t5 ", boot_tbl[i].name}, qb_at(i),
            32'(boot_tbl[i].word));
    end
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 8; j++) begin
        check($sformatf("t5 grp%0d row%0d", g, j),
              qb_at(6 + 8 * g + j), {16'h0, 8'(j + 1), 8'h00});
      end
    end
    for (int g = 1; g < 4; g++) begin
      if (tb_cyc.size() > 6 + 8 * g) begin
        check($sformatf("t5 period grp%0d", g),
              32'(tb_cyc[6 + 8 * g] - tb_cyc[6 + 8 * (g - 1)]),
              32'd50);
      end else begin
        check($sformatf("t5 period grp%0d missing", g),
              32'(tb_cyc.size()), 32'(7 + 8 * g));
      end
    end
    check("t5 init_done", 32'(init_done_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
